// File: rtl/pe_layer_sequencer_if.sv
// Broadcast bus between the layer scheduler, the layer sequencer and the PE array.
// The sequencer uses the slave view; the scheduler side uses the master view.
interface pe_layer_sequencer_if #(
    parameter int unsigned LDM_ADDR_BITS = 6,
    parameter int unsigned S_LDM_BITS    = 2,
    parameter int unsigned D_LDM_BITS    = 2,
    parameter int unsigned SA_LDM_BITS   = 6,
    parameter int unsigned ALU_CFG_BITS  = 4
);
    logic                                start_in;
    logic [ALU_CFG_BITS-1:0]             cfg_in;
    logic [S_LDM_BITS-1:0]               src_sel_in;
    logic [D_LDM_BITS-1:0]               dst_sel_in;
    logic [LDM_ADDR_BITS-1:0]            src_base_in;
    logic [SA_LDM_BITS-1:0]              store_base_in;
    logic [LDM_ADDR_BITS-1:0]            row_len_in;
    logic [LDM_ADDR_BITS-1:0]            num_rows_in;
    logic                                stride_in;
    logic                                padding_in;
    logic                                stall_in;

    logic                                busy_out;
    logic                                En_out;
    logic                                layer_done_out;
    logic [ALU_CFG_BITS-1:0]             CFG_out;
    logic                                Stride_out;
    logic                                Padding_Read_out;
    logic                                Parity_PE_Selection_out;
    logic [S_LDM_BITS+LDM_ADDR_BITS-1:0] CTRL_LDM_addra_out;
    logic [S_LDM_BITS+LDM_ADDR_BITS-1:0] CTRL_LDM_addrb_out;
    logic                                CTRL_LDM_ena_out;
    logic                                CTRL_LDM_enb_out;
    logic                                CTRL_LDM_wea_out;
    logic                                CTRL_LDM_web_out;
    logic [D_LDM_BITS+SA_LDM_BITS-1:0]   CTRL_LDM_Store_out;

    modport master (
        output start_in, cfg_in, src_sel_in, dst_sel_in, src_base_in, store_base_in,
               row_len_in, num_rows_in, stride_in, padding_in, stall_in,
        input  busy_out, En_out, layer_done_out, CFG_out, Stride_out, Padding_Read_out,
               Parity_PE_Selection_out, CTRL_LDM_addra_out, CTRL_LDM_addrb_out,
               CTRL_LDM_ena_out, CTRL_LDM_enb_out, CTRL_LDM_wea_out, CTRL_LDM_web_out,
               CTRL_LDM_Store_out
    );

    modport slave (
        input  start_in, cfg_in, src_sel_in, dst_sel_in, src_base_in, store_base_in,
               row_len_in, num_rows_in, stride_in, padding_in, stall_in,
        output busy_out, En_out, layer_done_out, CFG_out, Stride_out, Padding_Read_out,
               Parity_PE_Selection_out, CTRL_LDM_addra_out, CTRL_LDM_addrb_out,
               CTRL_LDM_ena_out, CTRL_LDM_enb_out, CTRL_LDM_wea_out, CTRL_LDM_web_out,
               CTRL_LDM_Store_out
    );
endinterface

// File: rtl/pe_layer_sequencer.sv
// Per-layer controller: latches a descriptor, walks the source LDM row by row,
// drains the ALU pipeline and pulses layer_done to the PE array.
module pe_layer_sequencer #(
    parameter int unsigned LDM_ADDR_BITS = 6,
    parameter int unsigned S_LDM_BITS    = 2,
    parameter int unsigned D_LDM_BITS    = 2,
    parameter int unsigned SA_LDM_BITS   = 6,
    parameter int unsigned ALU_CFG_BITS  = 4,
    parameter int unsigned DRAIN_CYCLES  = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    pe_layer_sequencer_if.slave   bus
);
    localparam int unsigned AW = LDM_ADDR_BITS;
    localparam int unsigned PW = LDM_ADDR_BITS + 1;
    localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                  state_q, state_d;
    logic [ALU_CFG_BITS-1:0] cfg_q, cfg_d;
    logic [S_LDM_BITS-1:0]   src_sel_q, src_sel_d;
    logic [D_LDM_BITS-1:0]   dst_sel_q, dst_sel_d;
    logic [SA_LDM_BITS-1:0]  store_base_q, store_base_d;
    logic [AW-1:0]           row_len_q, row_len_d;
    logic [AW-1:0]           num_rows_q, num_rows_d;
    logic                    stride_q, stride_d;
    logic                    padding_q, padding_d;
    logic [PW-1:0]           issues_q, issues_d;
    logic                    empty_q, empty_d;
    logic [AW-1:0]           col_q, col_d;
    logic [AW-1:0]           row_q, row_d;
    logic [AW-1:0]           row_base_q, row_base_d;
    logic                    parity_q, parity_d;
    logic [DW-1:0]           drain_q, drain_d;

    logic                    issue_c;
    logic                    en_c;
    logic [AW-1:0]           col_off_c;
    logic [AW-1:0]           addr_a_c;

    // State and descriptor registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            cfg_q        <= '0;
            src_sel_q    <= '0;
            dst_sel_q    <= '0;
            store_base_q <= '0;
            row_len_q    <= '0;
            num_rows_q   <= '0;
            stride_q     <= 1'b0;
            padding_q    <= 1'b0;
            issues_q     <= '0;
            empty_q      <= 1'b0;
            col_q        <= '0;
            row_q        <= '0;
            row_base_q   <= '0;
            parity_q     <= 1'b0;
            drain_q      <= '0;
        end else begin
            state_q      <= state_d;
            cfg_q        <= cfg_d;
            src_sel_q    <= src_sel_d;
            dst_sel_q    <= dst_sel_d;
            store_base_q <= store_base_d;
            row_len_q    <= row_len_d;
            num_rows_q   <= num_rows_d;
            stride_q     <= stride_d;
            padding_q    <= padding_d;
            issues_q     <= issues_d;
            empty_q      <= empty_d;
            col_q        <= col_d;
            row_q        <= row_d;
            row_base_q   <= row_base_d;
            parity_q     <= parity_d;
            drain_q      <= drain_d;
        end
    end

    // Next-state, counter and enable logic
    always_comb begin
        state_d      = state_q;
        cfg_d        = cfg_q;
        src_sel_d    = src_sel_q;
        dst_sel_d    = dst_sel_q;
        store_base_d = store_base_q;
        row_len_d    = row_len_q;
        num_rows_d   = num_rows_q;
        stride_d     = stride_q;
        padding_d    = padding_q;
        issues_d     = issues_q;
        empty_d      = empty_q;
        col_d        = col_q;
        row_d        = row_q;
        row_base_d   = row_base_q;
        parity_d     = parity_q;
        drain_d      = drain_q;
        issue_c      = 1'b0;
        en_c         = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start_in) begin
                    cfg_d        = bus.cfg_in;
                    src_sel_d    = bus.src_sel_in;
                    dst_sel_d    = bus.dst_sel_in;
                    store_base_d = bus.store_base_in;
                    row_len_d    = bus.row_len_in;
                    num_rows_d   = bus.num_rows_in;
                    stride_d     = bus.stride_in;
                    padding_d    = bus.padding_in;
                    issues_d     = bus.stride_in ? ((PW'(bus.row_len_in) + PW'(1)) >> 1)
                                                 : PW'(bus.row_len_in);
                    empty_d      = (bus.row_len_in == '0) || (bus.num_rows_in == '0);
                    col_d        = '0;
                    row_d        = '0;
                    row_base_d   = bus.src_base_in;
                    parity_d     = 1'b0;
                    drain_d      = '0;
                    state_d      = RUN;
                end
            end
            RUN: begin
                // An empty layer spends one quiet cycle here and issues nothing
                if (empty_q) begin
                    state_d = DONE;
                end else if (!bus.stall_in) begin
                    issue_c = 1'b1;
                    en_c    = 1'b1;
                    if ({1'b0, col_q} == (issues_q - PW'(1))) begin
                        col_d      = '0;
                        row_base_d = row_base_q + row_len_q;
                        row_d      = row_q + AW'(1);
                        parity_d   = stride_q ? ~parity_q : 1'b0;
                        if (row_q == (num_rows_q - AW'(1))) begin
                            state_d = DRAIN;
                        end
                    end else begin
                        col_d = col_q + AW'(1);
                    end
                end
            end
            DRAIN: begin
                en_c = 1'b1;
                if (drain_q == DW'(DRAIN_CYCLES - 1)) begin
                    drain_d = '0;
                    state_d = DONE;
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            DONE: begin
                col_d      = '0;
                row_d      = '0;
                row_base_d = '0;
                parity_d   = 1'b0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Read address: stride 2 skips every other pixel; port B reads the next row
    assign col_off_c = stride_q ? {col_q[AW-2:0], 1'b0} : col_q;
    assign addr_a_c  = row_base_q + col_off_c;

    assign bus.busy_out                = (state_q != IDLE);
    assign bus.En_out                  = en_c;
    assign bus.layer_done_out          = (state_q == DONE);
    assign bus.CFG_out                 = cfg_q;
    assign bus.Stride_out              = stride_q;
    assign bus.Padding_Read_out        = padding_q;
    assign bus.Parity_PE_Selection_out = parity_q;
    assign bus.CTRL_LDM_addra_out      = {src_sel_q, addr_a_c};
    assign bus.CTRL_LDM_addrb_out      = {src_sel_q, addr_a_c + row_len_q};
    assign bus.CTRL_LDM_ena_out        = issue_c;
    assign bus.CTRL_LDM_enb_out        = issue_c;
    assign bus.CTRL_LDM_wea_out        = 1'b0;
    assign bus.CTRL_LDM_web_out        = 1'b0;
    assign bus.CTRL_LDM_Store_out      = {dst_sel_q, store_base_q};
endmodule

// File: tb/tb_pe_layer_sequencer.sv
// Self-checking bench for pe_layer_sequencer: a queue-based layer model checked every
// cycle, plus directed scenarios with hand-computed addresses and latencies.
module tb_pe_layer_sequencer;
    localparam int unsigned AW  = 6;
    localparam int unsigned SB  = 2;
    localparam int unsigned DB  = 2;
    localparam int unsigned SAB = 6;
    localparam int unsigned CB  = 4;
    localparam int unsigned DR  = 4;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    pe_layer_sequencer_if #(.LDM_ADDR_BITS(AW), .S_LDM_BITS(SB), .D_LDM_BITS(DB),
                            .SA_LDM_BITS(SAB), .ALU_CFG_BITS(CB)) bus ();

    pe_layer_sequencer #(.LDM_ADDR_BITS(AW), .S_LDM_BITS(SB), .D_LDM_BITS(DB),
                         .SA_LDM_BITS(SAB), .ALU_CFG_BITS(CB), .DRAIN_CYCLES(DR))
        dut (.CLK(CLK), .RST(RST), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // Reference model: a layer is a list of reads, then DR drain cycles, then one done cycle
    typedef struct { int a; int p; } iss_t;
    iss_t mq[$];
    iss_t f;
    bit   m_act, m_quiet, was;
    int   m_drain;
    int   m_cfg, m_ss, m_ds, m_sb, m_st, m_pad, m_rl;
    int   cyc, start_cyc, done_cyc, done_count;
    int   obs_a[$], obs_p[$];
    int   e_en, e_ena, e_done;

    initial begin
        m_act = 0; m_quiet = 0; m_drain = 0;
        m_cfg = 0; m_ss = 0; m_ds = 0; m_sb = 0; m_st = 0; m_pad = 0; m_rl = 0;
        cyc = 0; start_cyc = 0; done_cyc = 0; done_count = 0;
    end

    always @(negedge CLK) begin
        cyc++;
        if (RST) begin
            m_act = 0; m_quiet = 0; m_drain = 0; mq.delete();
            m_cfg = 0; m_ss = 0; m_ds = 0; m_sb = 0; m_st = 0; m_pad = 0; m_rl = 0;
        end else begin
            was = m_act;
            e_en = 0; e_ena = 0; e_done = 0;
            if (!m_act) begin
                chk("idle_parity", int'(bus.Parity_PE_Selection_out), 0);
            end else if (mq.size() > 0) begin
                if (!bus.stall_in) begin
                    f = mq.pop_front();
                    e_en = 1; e_ena = 1;
                    chk("addra", int'(bus.CTRL_LDM_addra_out), (m_ss << AW) | f.a);
                    chk("addrb", int'(bus.CTRL_LDM_addrb_out), (m_ss << AW) | ((f.a + m_rl) % 64));
                    chk("parity", int'(bus.Parity_PE_Selection_out), f.p);
                end
            end else if (m_quiet) begin
                m_quiet = 0;
            end else if (m_drain > 0) begin
                e_en = 1;
                m_drain--;
            end else begin
                e_done = 1;
                m_act  = 0;
            end
            chk("busy", int'(bus.busy_out), int'(was));
            chk("En", int'(bus.En_out), e_en);
            chk("ena", int'(bus.CTRL_LDM_ena_out), e_ena);
            chk("enb", int'(bus.CTRL_LDM_enb_out), e_ena);
            chk("done", int'(bus.layer_done_out), e_done);
            chk("wea", int'(bus.CTRL_LDM_wea_out), 0);
            chk("web", int'(bus.CTRL_LDM_web_out), 0);
            chk("cfg", int'(bus.CFG_out), m_cfg);
            chk("stride", int'(bus.Stride_out), m_st);
            chk("pad", int'(bus.Padding_Read_out), m_pad);
            chk("store", int'(bus.CTRL_LDM_Store_out), (m_ds << SAB) | m_sb);

            if (bus.layer_done_out) begin
                done_cyc = cyc;
                done_count++;
            end
            if (bus.CTRL_LDM_ena_out) begin
                obs_a.push_back(int'(bus.CTRL_LDM_addra_out[AW-1:0]));
                obs_p.push_back(int'(bus.Parity_PE_Selection_out));
            end

            if (bus.start_in && !was) begin
                int src, nr, pcnt;
                m_cfg = int'(bus.cfg_in);      m_ss  = int'(bus.src_sel_in);
                m_ds  = int'(bus.dst_sel_in);  m_sb  = int'(bus.store_base_in);
                m_st  = int'(bus.stride_in);   m_pad = int'(bus.padding_in);
                m_rl  = int'(bus.row_len_in);
                src   = int'(bus.src_base_in); nr    = int'(bus.num_rows_in);
                pcnt  = m_st != 0 ? (m_rl + 1) / 2 : m_rl;
                mq.delete();
                for (int r = 0; r < nr; r++) begin
                    for (int c = 0; c < pcnt; c++) begin
                        iss_t it;
                        it.a = (src + r * m_rl + c * (m_st + 1)) % 64;
                        it.p = m_st != 0 ? r % 2 : 0;
                        mq.push_back(it);
                    end
                end
                m_quiet   = (mq.size() == 0);
                m_drain   = m_quiet ? 0 : DR;
                m_act     = 1;
                start_cyc = cyc;
            end
        end
    end

    task automatic start_layer(input int cfg, input int ss, input int ds, input int sb,
                               input int src, input int rl, input int nr, input int st,
                               input int pad);
        @(posedge CLK); #1;
        bus.cfg_in        = CB'(cfg);
        bus.src_sel_in    = SB'(ss);
        bus.dst_sel_in    = DB'(ds);
        bus.store_base_in = SAB'(sb);
        bus.src_base_in   = AW'(src);
        bus.row_len_in    = AW'(rl);
        bus.num_rows_in   = AW'(nr);
        bus.stride_in     = st[0];
        bus.padding_in    = pad[0];
        bus.stall_in      = 1'b0;
        bus.start_in      = 1'b1;
        @(posedge CLK); #1;
        bus.start_in      = 1'b0;
    endtask

    task automatic wait_done(input bit rnd, output int lat);
        int c0;
        c0 = done_count;
        for (int i = 0; i < 2000 && done_count == c0; i++) begin
            bus.stall_in = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
            @(posedge CLK); #1;
        end
        bus.stall_in = 1'b0;
        chk("done_timeout", int'(done_count != c0), 1);
        lat = done_cyc - start_cyc;
    endtask

    task automatic check_q(input string nm, input int got[$], input int want[$]);
        chk({nm, "_len"}, got.size(), want.size());
        for (int i = 0; i < want.size() && i < got.size(); i++)
            chk(nm, got[i], want[i]);
    endtask

    initial begin
        int lat, dc;
        bus.start_in = 0; bus.cfg_in = '0; bus.src_sel_in = '0; bus.dst_sel_in = '0;
        bus.src_base_in = '0; bus.store_base_in = '0; bus.row_len_in = '0;
        bus.num_rows_in = '0; bus.stride_in = 0; bus.padding_in = 0; bus.stall_in = 0;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        @(posedge CLK); #1;
        chk("rst_busy", int'(bus.busy_out), 0);
        chk("rst_cfg", int'(bus.CFG_out), 0);
        chk("rst_addra", int'(bus.CTRL_LDM_addra_out), 0);

        // Basic row walk
        obs_a.delete(); obs_p.delete();
        start_layer(5, 1, 2, 9, 0, 4, 2, 0, 1);
        wait_done(0, lat);
        chk("basic_lat", lat, 13);
        check_q("basic_addr", obs_a, '{0, 1, 2, 3, 4, 5, 6, 7});

        // Stride 2 with parity toggling per row
        obs_a.delete(); obs_p.delete();
        start_layer(2, 0, 1, 3, 0, 5, 2, 1, 0);
        wait_done(0, lat);
        chk("stride_lat", lat, 11);
        check_q("stride_addr", obs_a, '{0, 2, 4, 5, 7, 9});
        check_q("stride_par", obs_p, '{0, 0, 0, 1, 1, 1});
        chk("stride_par_after", int'(bus.Parity_PE_Selection_out), 0);

        // Two stalled cycles on issues 2 and 3
        obs_a.delete(); obs_p.delete();
        start_layer(5, 1, 2, 9, 0, 4, 2, 0, 1);
        @(posedge CLK); #1 bus.stall_in = 1'b1;
        @(posedge CLK); #1 bus.stall_in = 1'b1;
        @(posedge CLK); #1 bus.stall_in = 1'b0;
        wait_done(0, lat);
        chk("stall_lat", lat, 15);
        check_q("stall_addr", obs_a, '{0, 1, 2, 3, 4, 5, 6, 7});

        // Address wrap
        obs_a.delete(); obs_p.delete();
        start_layer(1, 3, 0, 0, 62, 4, 1, 0, 0);
        wait_done(0, lat);
        chk("wrap_lat", lat, 9);
        check_q("wrap_addr", obs_a, '{62, 63, 0, 1});

        // Zero-length layers
        obs_a.delete(); obs_p.delete();
        start_layer(7, 2, 3, 1, 5, 3, 0, 0, 0);
        wait_done(0, lat);
        chk("zero_rows_lat", lat, 2);
        chk("zero_rows_reads", obs_a.size(), 0);
        start_layer(6, 2, 3, 1, 5, 0, 3, 1, 0);
        wait_done(0, lat);
        chk("zero_len_lat", lat, 2);
        chk("zero_len_reads", obs_a.size(), 0);

        // Start while busy is ignored
        obs_a.delete(); obs_p.delete();
        start_layer(3, 1, 2, 9, 0, 4, 2, 0, 0);
        @(posedge CLK); #1;
        bus.cfg_in = CB'(9); bus.src_base_in = AW'(20); bus.start_in = 1'b1;
        @(posedge CLK); #1 bus.start_in = 1'b0;
        wait_done(0, lat);
        chk("busy_start_lat", lat, 13);
        chk("busy_start_cfg", int'(bus.CFG_out), 3);
        check_q("busy_start_addr", obs_a, '{0, 1, 2, 3, 4, 5, 6, 7});

        // Reset mid-layer, then a clean layer
        dc = done_count;
        start_layer(4, 1, 1, 7, 0, 4, 2, 0, 1);
        @(posedge CLK); #1 RST = 1'b1;
        @(posedge CLK); #1 RST = 1'b0;
        chk("midrst_busy", int'(bus.busy_out), 0);
        chk("midrst_en", int'(bus.En_out), 0);
        chk("midrst_cfg", int'(bus.CFG_out), 0);
        chk("midrst_store", int'(bus.CTRL_LDM_Store_out), 0);
        chk("midrst_addra", int'(bus.CTRL_LDM_addra_out), 0);
        repeat (6) @(posedge CLK);
        #1 chk("midrst_no_done", done_count, dc);
        obs_a.delete(); obs_p.delete();
        start_layer(4, 1, 1, 7, 10, 3, 2, 0, 0);
        wait_done(0, lat);
        chk("postrst_lat", lat, 11);
        check_q("postrst_addr", obs_a, '{10, 11, 12, 13, 14, 15});

        // Randomized layers with random stalls
        for (int k = 0; k < 30; k++) begin
            start_layer(int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                        int'($urandom_range(0, 3)), int'($urandom_range(0, 63)),
                        int'($urandom_range(0, 63)), int'($urandom_range(0, 12)),
                        int'($urandom_range(0, 5)), int'($urandom_range(0, 1)),
                        int'($urandom_range(0, 1)));
            wait_done(1, lat);
            repeat (int'($urandom_range(0, 2))) @(posedge CLK);
        end

        repeat (2) @(posedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
